// File: rtl/hazard_stall_unit.sv
// Load-use hazard detector and stall/flush controller for a decode/execute pipeline.
// Optional macro HAZARD_STALL_PERF_CNT_EN adds a saturating StallCycles counter.
module hazard_stall_unit #(
   parameter int unsigned MEM_LAT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] R2_1,
   input  logic [3:0] R3_1,
   input  logic [1:0] ExtndSel0,
   input  logic [3:0] DestR_2,
   input  logic       MemRd_2,
   input  logic       BranchTaken_2,
   output logic       StallF,
   output logic       StallD,
   output logic       FlushD,
   output logic       FlushE,
   output logic       Busy
`ifdef HAZARD_STALL_PERF_CNT_EN
   ,
   output logic [15:0] StallCycles
`endif
);

   localparam int unsigned REG_W  = 4;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned PERF_W = 16;

   typedef enum logic {
      IDLE      = 1'b0,
      LOAD_WAIT = 1'b1
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;

   logic               use2_c;
   logic               use3_c;
   logic               hazard_c;

   // R0 is hard-wired zero, so a load targeting it can never be a producer.
   always_comb begin
      use2_c   = ExtndSel0[1];
      use3_c   = ExtndSel0[1] & ~ExtndSel0[0];
      hazard_c = MemRd_2 & (DestR_2 != REG_W'(0)) &
                 ((use2_c & (R2_1 == DestR_2)) | (use3_c & (R3_1 == DestR_2)));
   end

   // Next-state and control outputs; reset forces every output low.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      StallF  = 1'b0;
      StallD  = 1'b0;
      FlushD  = 1'b0;
      FlushE  = 1'b0;
      Busy    = 1'b0;

      if (!rst) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (BranchTaken_2) begin
                  FlushD = 1'b1;
                  FlushE = 1'b1;
               end else if (hazard_c) begin
                  StallF = 1'b1;
                  StallD = 1'b1;
                  FlushE = 1'b1;
                  if (MEM_LAT > 1) begin
                     state_d = LOAD_WAIT;
                     cnt_d   = CNT_W'(MEM_LAT - 1);
                  end
               end
            end

            LOAD_WAIT: begin
               Busy = 1'b1;
               if (BranchTaken_2) begin
                  FlushD  = 1'b1;
                  FlushE  = 1'b1;
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  StallF = 1'b1;
                  StallD = 1'b1;
                  FlushE = 1'b1;
                  cnt_d  = cnt_q - CNT_W'(1);
                  // cnt==0 is unreachable; treat it as the last cycle for safety.
                  if (cnt_q <= CNT_W'(1)) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end
               end
            end

            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZARD_STALL_PERF_CNT_EN
   // Counts decode-stall cycles, sticking at all-ones.
   always_ff @(posedge clk) begin
      if (!rst) begin
         StallCycles <= '0;
      end else if (StallD && (StallCycles != {PERF_W{1'b1}})) begin
         StallCycles <= StallCycles + PERF_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench: four DUT copies (MEM_LAT=1..4) on shared inputs, checked
// every cycle against a remaining-stall-cycles model plus directed literal checks.
module tb_hazard_stall_unit;

   localparam int unsigned N = 4;

   logic       clk;
   logic       rst;
   logic [3:0] r2;
   logic [3:0] r3;
   logic [1:0] sel;
   logic [3:0] dest;
   logic       memrd;
   logic       br;

   logic       sf   [N];
   logic       sd   [N];
   logic       fd   [N];
   logic       fe   [N];
   logic       busy [N];
`ifdef HAZARD_STALL_PERF_CNT_EN
   logic [15:0] sc  [N];
   int          pc  [N];
`endif

   int   n_cmp = 0;
   int   n_err = 0;
   int   rem    [N];
   int   rem_nx [N];
   logic sd_exp [N];
   bit   started = 0;

   for (genvar g = 0; g < N; g++) begin : g_dut
      hazard_stall_unit #(.MEM_LAT(g + 1)) u_dut (
         .clk           (clk),
         .rst           (rst),
         .R2_1          (r2),
         .R3_1          (r3),
         .ExtndSel0     (sel),
         .DestR_2       (dest),
         .MemRd_2       (memrd),
         .BranchTaken_2 (br),
         .StallF        (sf[g]),
         .StallD        (sd[g]),
         .FlushD        (fd[g]),
         .FlushE        (fe[g]),
         .Busy          (busy[g])
`ifdef HAZARD_STALL_PERF_CNT_EN
         ,
         .StallCycles   (sc[g])
`endif
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: rem = stall cycles still owed after the current one; o = {StallF,StallD,FlushD,FlushE,Busy}.
   function automatic void model(input int lat, input int rm, input logic rs,
                                 input logic [3:0] a2, input logic [3:0] a3,
                                 input logic [1:0] s, input logic [3:0] d,
                                 input logic m, input logic b,
                                 output logic [4:0] o, output int rn);
      logic hz;
      hz = m && (d != 4'd0) && ((s[1] && a2 == d) || (s == 2'b10 && a3 == d));
      o  = 5'b00000;
      rn = rm;
      if (!rs) begin
         rn = 0;
      end else if (rm > 0) begin
         if (b) begin
            o  = 5'b00111;
            rn = 0;
         end else begin
            o  = 5'b11011;
            rn = rm - 1;
         end
      end else if (b) begin
         o = 5'b00110;
      end else if (hz) begin
         o  = 5'b11010;
         rn = lat - 1;
      end
   endfunction

   function automatic logic [4:0] outs(input int i);
      return {sf[i], sd[i], fd[i], fe[i], busy[i]};
   endfunction

   initial begin
      for (int i = 0; i < N; i++) begin
         rem[i] = 0;
         rem_nx[i] = 0;
         sd_exp[i] = 1'b0;
`ifdef HAZARD_STALL_PERF_CNT_EN
         pc[i] = 0;
`endif
      end
   end

   // Every-cycle comparison of all instances against the model.
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         logic [4:0] e;
         int         rn;
         model(i + 1, rem[i], rst, r2, r3, sel, dest, memrd, br, e, rn);
         rem_nx[i] = rn;
         sd_exp[i] = e[3];
         n_cmp++;
         if (outs(i) !== e) begin
            n_err++;
            $display("FAIL model_lat%0d t=%0t got=%b exp=%b", i + 1, $time, outs(i), e);
         end
`ifdef HAZARD_STALL_PERF_CNT_EN
         if (started) begin
            n_cmp++;
            if (sc[i] !== 16'(pc[i])) begin
               n_err++;
               $display("FAIL perf_lat%0d t=%0t got=%0d exp=%0d", i + 1, $time, sc[i], pc[i]);
            end
         end
`endif
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         rem[i] = rem_nx[i];
`ifdef HAZARD_STALL_PERF_CNT_EN
         if (!rst) pc[i] = 0;
         else if (sd_exp[i] && pc[i] < 65535) pc[i] = pc[i] + 1;
`endif
      end
      started = 1;
   end

   task automatic lit(input string name, input logic [4:0] got, input logic [4:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%b exp=%b", name, got, exp);
      end
   endtask

   task automatic drv(input logic [3:0] a2, input logic [3:0] a3, input logic [1:0] s,
                      input logic [3:0] d, input logic m, input logic b);
      @(posedge clk);
      #1;
      r2 = a2; r3 = a3; sel = s; dest = d; memrd = m; br = b;
   endtask

   task automatic smp();
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drv(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b0;
      r2 = 4'd5; r3 = 4'd0; sel = 2'b10; dest = 4'd5; memrd = 1'b1; br = 1'b0;
      // Reset with a live hazard on the inputs: outputs stay low.
      smp();
      lit("reset_lat2", outs(1), 5'b00000);
      lit("reset_lat4", outs(3), 5'b00000);
      drv(4'd5, 4'd0, 2'b10, 4'd5, 1'b1, 1'b1);
      smp();
      lit("reset_branch", outs(1), 5'b00000);
      idle(1);
      rst = 1'b1;
      idle(2);

      // Basic load-use stall, MEM_LAT=2.
      drv(4'd5, 4'd0, 2'b10, 4'd5, 1'b1, 1'b0);
      smp(); lit("lu_c1_lat2", outs(1), 5'b11010);
      lit("lu_c1_lat1", outs(0), 5'b11010);
      drv(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
      smp(); lit("lu_c2_lat2", outs(1), 5'b11011);
      lit("lu_c2_lat1", outs(0), 5'b00000);
      drv(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
      smp(); lit("lu_c3_lat2", outs(1), 5'b00000);
      idle(4);

      // R3 ignored for ExtndSel0=11, compared for 10.
      drv(4'd3, 4'd7, 2'b11, 4'd7, 1'b1, 1'b0);
      smp(); lit("r3_unread", outs(1), 5'b00000);
      drv(4'd3, 4'd7, 2'b10, 4'd7, 1'b1, 1'b0);
      smp(); lit("r3_read", outs(1), 5'b11010);
      idle(5);

      // Destination R0 never hazards.
      drv(4'd0, 4'd0, 2'b10, 4'd0, 1'b1, 1'b0);
      smp(); lit("dest_r0", outs(1), 5'b00000);
      lit("dest_r0_lat4", outs(3), 5'b00000);
      idle(2);

      // Branch aborts a MEM_LAT=4 stall in its second cycle.
      drv(4'd9, 4'd0, 2'b10, 4'd9, 1'b1, 1'b0);
      smp(); lit("abort_c1", outs(3), 5'b11010);
      drv(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b1);
      smp(); lit("abort_c2", outs(3), 5'b00111);
      drv(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
      smp(); lit("abort_c3", outs(3), 5'b00000);
      idle(2);

      // Branch and hazard together: flush only.
      drv(4'd5, 4'd0, 2'b10, 4'd5, 1'b1, 1'b1);
      smp(); lit("br_hz_c1", outs(1), 5'b00110);
      drv(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
      smp(); lit("br_hz_c2", outs(3), 5'b00000);
      idle(2);

      // Back-to-back windows while the decode instruction keeps matching.
      drv(4'd6, 4'd0, 2'b10, 4'd6, 1'b1, 1'b0);
      smp(); lit("b2b_c1", outs(1), 5'b11010);
      drv(4'd6, 4'd0, 2'b10, 4'd6, 1'b1, 1'b0);
      smp(); lit("b2b_c2", outs(1), 5'b11011);
      drv(4'd6, 4'd0, 2'b10, 4'd6, 1'b1, 1'b0);
      smp(); lit("b2b_c3", outs(1), 5'b11010);
      drv(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
      smp(); lit("b2b_c4", outs(1), 5'b11011);
      idle(5);

      // Reset in the second cycle of a MEM_LAT=3 stall.
      drv(4'd2, 4'd0, 2'b10, 4'd2, 1'b1, 1'b0);
      smp(); lit("rst_mid_c1", outs(2), 5'b11010);
      drv(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
      rst = 1'b0;
      smp(); lit("rst_mid_c2", outs(2), 5'b00000);
      drv(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
      rst = 1'b1;
      smp(); lit("rst_mid_c3", outs(2), 5'b00000);
`ifdef HAZARD_STALL_PERF_CNT_EN
      n_cmp++;
      if (sc[2] !== 16'd0) begin
         n_err++;
         $display("FAIL perf_after_reset got=%0d exp=0", sc[2]);
      end
`endif
      drv(4'd4, 4'd0, 2'b10, 4'd4, 1'b1, 1'b0);
      smp(); lit("full_lat3_c1", outs(2), 5'b11010);
      drv(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
      smp(); lit("full_lat3_c2", outs(2), 5'b11011);
      drv(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
      smp(); lit("full_lat3_c3", outs(2), 5'b11011);
      drv(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
      smp(); lit("full_lat3_c4", outs(2), 5'b00000);
`ifdef HAZARD_STALL_PERF_CNT_EN
      n_cmp++;
      if (sc[2] !== 16'd3) begin
         n_err++;
         $display("FAIL perf_one_hazard got=%0d exp=3", sc[2]);
      end
`endif
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 Parameter MEM_LAT, 2: load-use stall length in cycles, legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 R2_1  input  4  decode-stage first source register.
REQ-005 R3_1  input  4  decode-stage second source register.
REQ-006 ExtndSel0  input  2  decode-stage instruction class: bit1 = R2 is read; R3 is read only when bit1=1 and bit0=0 (DT).
REQ-007 DestR_2  input  4  execute-stage destination register.
REQ-008 MemRd_2  input  1  execute-stage instruction is a memory load.
REQ-009 BranchTaken_2  input  1  execute-stage branch resolved taken.
REQ-010 StallF  output  1  hold fetch PC.
REQ-011 StallD  output  1  hold the decode pipeline register.
REQ-012 FlushD  output  1  clear the decode pipeline register.
REQ-013 FlushE  output  1  clear the execute pipeline register (insert bubble).
REQ-014 Busy  output  1  FSM is in LOAD_WAIT.

Function
REQ-015 Register 0 never causes a hazard; a compare against R0 is always false.
REQ-016 use2 = ExtndSel0[1]; use3 = ExtndSel0[1] & ~ExtndSel0[0].
REQ-017 hazard = MemRd_2 & (DestR_2 != 0) & ((use2 & R2_1 == DestR_2) | (use3 & R3_1 == DestR_2)).
REQ-018 States: IDLE, LOAD_WAIT. A 4-bit down-counter cnt tracks remaining stall cycles.
REQ-019 IDLE, BranchTaken_2=1: FlushD=FlushE=1, StallF=StallD=0; remain IDLE. Branch wins over hazard in the same cycle.
REQ-020 IDLE, hazard=1, no branch: StallF=StallD=FlushE=1 in the same cycle (combinational); if MEM_LAT>1, load cnt=MEM_LAT-1 and go to LOAD_WAIT, else remain IDLE.
REQ-021 LOAD_WAIT: StallF=StallD=FlushE=1, Busy=1; decode inputs are ignored; cnt decrements each cycle; when cnt==1, the next state is IDLE.
REQ-022 The total stall for one load-use hazard is exactly MEM_LAT consecutive cycles.
REQ-023 LOAD_WAIT, BranchTaken_2=1: abort the stall; FlushD=FlushE=1, StallF=StallD=0 that cycle; next state IDLE, cnt=0.
REQ-024 A new hazard is evaluated only in IDLE; back-to-back hazards produce back-to-back stall windows, with no idle cycle, when the decode instruction still matches.
REQ-025 Outside the cases above, all control outputs are 0.
REQ-026 Control outputs are combinational from state and inputs; state and cnt are registered.

Reset
REQ-027 rst=0 at a rising edge forces state=IDLE and cnt=0 (and StallCycles=0 when compiled in).
REQ-028 While rst=0, all outputs are 0 regardless of the other inputs.
REQ-029 Reset in mid-stall: stall outputs drop in the reset cycle, and the FSM resumes in IDLE after rst=1.

Configuration
REQ-030 Macro HAZARD_STALL_PERF_CNT_EN defined: add output StallCycles [15:0], incremented in every cycle with StallD=1, saturating at 16'hFFFF.
REQ-031 Macro undefined: no StallCycles port and no counter logic; all other behaviour is identical.

Verification
REQ-032 MEM_LAT=2; R2_1=5, ExtndSel0=2'b10, DestR_2=5, MemRd_2=1 -> StallF/StallD/FlushE high exactly 2 cycles, Busy high in cycle 2 only.
REQ-033 ExtndSel0=2'b11, R3_1=7, R2_1=3, DestR_2=7, MemRd_2=1 -> no stall (R3 not read); the same with ExtndSel0=2'b10 -> stall.
REQ-034 DestR_2=0, R2_1=0, MemRd_2=1, ExtndSel0=2'b10 -> no stall.
REQ-035 MEM_LAT=4; hazard, then BranchTaken_2=1 in the 2nd stall cycle -> that cycle FlushD=FlushE=1, StallF=0; IDLE the next cycle.
REQ-036 Hazard and BranchTaken_2 in the same cycle -> flush only, no stall, state stays IDLE.
REQ-037 MEM_LAT=3; rst=0 asserted in the 2nd stall cycle -> all outputs 0 that cycle, IDLE afterwards; with HAZARD_STALL_PERF_CNT_EN, StallCycles=0 after reset, then 3 after one full hazard.
